// File: rtl/ext_mem_pkg.sv
// Shared types for the external memory responder: FSM state encoding and wait-counter width.
// Used by ext_mem_responder and ext_mem_array (optional parity via EXT_MEM_PARITY_EN).
package ext_mem_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ext_mem_array.sv
// Byte storage for the responder: synchronous write, combinational read, no reset on contents.
// Defining EXT_MEM_PARITY_EN adds an even-parity column and a read parity-error flag.
module ext_mem_array
    import ext_mem_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
`ifdef EXT_MEM_PARITY_EN
    ,
    output logic              o_perr
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

`ifdef EXT_MEM_PARITY_EN
    // Stored bit makes the 9-bit word even; any odd total on read is an error.
    logic r_par [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_par[i_waddr] <= ^i_wdata;
        end
    end

    assign o_perr = (^o_rdata) ^ r_par[i_raddr];
`endif

endmodule

// File: rtl/ext_mem_responder.sv
// Single-outstanding byte memory responder with wait states and a byte-stream loader.
// Optional parity (macro EXT_MEM_PARITY_EN) adds the rsp_perr output.
module ext_mem_responder
    import ext_mem_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_rdata,
    input  logic              load_en,
    input  logic [7:0]        load_byte,
    output logic              busy,
    output state_t            dbg_state
`ifdef EXT_MEM_PARITY_EN
    ,
    output logic              rsp_perr
`endif
);

    // Handshakes: a beat transfers on a rising edge where valid && ready; the
    // response holds rsp_valid/rsp_rdata unchanged until rsp_ready is seen.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
        WAIT_CNT_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

    state_t                r_state;
    state_t                w_next_state;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [7:0]            r_wdata;
    logic [7:0]            r_rsp_rdata;
    logic [ADDR_W-1:0]     r_load_ptr;

    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_load_wr;
    logic                  w_to_resp;
    logic                  w_cur_we;
    logic [ADDR_W-1:0]     w_cur_addr;
    logic [7:0]            w_cur_wdata;
    logic                  w_mem_we;
    logic [ADDR_W-1:0]     w_mem_waddr;
    logic [7:0]            w_mem_wdata;
    logic [7:0]            w_mem_rdata;

    always_comb begin
        w_next_state = r_state;
        w_req_ready  = 1'b0;
        w_accept     = 1'b0;
        w_load_wr    = 1'b0;
        w_to_resp    = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = !load_en;
                w_load_wr   = load_en;
                if (req_valid && !load_en) begin
                    w_accept = 1'b1;
                    if (WAIT_CYC == 0) begin
                        w_next_state = RESP;
                        w_to_resp    = 1'b1;
                    end else begin
                        w_next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_wait_cnt == WAIT_LAST) begin
                    w_next_state = RESP;
                    w_to_resp    = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // With zero wait states the access completes on the accept edge itself,
    // so the live request fields stand in for the not-yet-latched copies.
    assign w_cur_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_cur_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_cur_wdata = (r_state == IDLE) ? req_wdata : r_wdata;

    assign w_mem_we    = w_load_wr || (w_to_resp && w_cur_we);
    assign w_mem_waddr = w_load_wr ? r_load_ptr : w_cur_addr;
    assign w_mem_wdata = w_load_wr ? load_byte  : w_cur_wdata;

`ifdef EXT_MEM_PARITY_EN
    logic w_mem_perr;
    logic r_rsp_perr;
`endif

    ext_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .i_clk   (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (w_mem_wdata),
        .i_raddr (w_cur_addr),
        .o_rdata (w_mem_rdata)
`ifdef EXT_MEM_PARITY_EN
        ,
        .o_perr  (w_mem_perr)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
            r_load_ptr  <= '0;
        end else begin
            r_state <= w_next_state;

            if (w_accept) begin
                r_we       <= req_we;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_wait_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_wait_cnt <= w_to_resp ? '0 : r_wait_cnt + 1'b1;
            end

            if (w_to_resp) begin
                r_rsp_rdata <= w_cur_we ? 8'h00 : w_mem_rdata;
            end

            // Pointer restarts whenever the loader is idle, so each burst begins at 0.
            if (!load_en) begin
                r_load_ptr <= '0;
            end else if (w_load_wr) begin
                r_load_ptr <= r_load_ptr + 1'b1;
            end
        end
    end

`ifdef EXT_MEM_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_perr <= 1'b0;
        end else if (w_to_resp) begin
            r_rsp_perr <= !w_cur_we && w_mem_perr;
        end else if (r_state == RESP && rsp_ready) begin
            r_rsp_perr <= 1'b0;
        end
    end

    assign rsp_perr = r_rsp_perr;
`endif

    assign req_ready = w_req_ready;
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed bench for ext_mem_responder (ADDR_W=5, WAIT_CYC=1); parity case under EXT_MEM_PARITY_EN.
module tb_ext_mem_responder;
  import ext_mem_pkg::*;

  localparam int ADDR_W   = 5;
  localparam int WAIT_CYC = 1;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_rdata;
  logic              load_en;
  logic [7:0]        load_byte;
  logic              busy;
  state_t            dbg_state;
`ifdef EXT_MEM_PARITY_EN
  logic              rsp_perr;
`endif

  int n_vec;
  int n_err;
  logic [7:0] exp_q[$];
  logic exp_perr;

  ext_mem_responder #(
    .ADDR_W   (ADDR_W),
    .WAIT_CYC (WAIT_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .load_en   (load_en),
    .load_byte (load_byte),
    .busy      (busy),
    .dbg_state (dbg_state)
`ifdef EXT_MEM_PARITY_EN
    ,
    .rsp_perr  (rsp_perr)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: one request, full response handshake; called and returns on a negedge.
  task automatic do_access(input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [7:0] wdata, input logic [7:0] exp_rd,
                           input int hold);
    int cyc;
    logic [7:0] exp_v;
    exp_q.push_back(exp_rd);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
    cyc = 0;
    while (!req_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!req_ready) check_val("accept_timeout", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_val("latency", 32'(cyc), 32'(WAIT_CYC + 1));
    exp_v = exp_q.pop_front();
    check_val("rdata", 32'(rsp_rdata), 32'(exp_v));
`ifdef EXT_MEM_PARITY_EN
    check_val("perr", 32'(rsp_perr), 32'(exp_perr));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val("hold_valid", 32'(rsp_valid), 32'd1);
      check_val("hold_rdata", 32'(rsp_rdata), 32'(exp_v));
      check_val("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_val("idle_after_rsp", 32'(busy), 32'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    exp_perr  = 1'b0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    load_en   = 1'b0;
    load_byte = '0;
    repeat (2) @(negedge clk);

    // reset state
    check_val("rst_req_ready", 32'(req_ready), 32'd1);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // write then read back, write response data is 0
    do_access(1'b1, 5'h03, 8'hA5, 8'h00, 0);
    do_access(1'b0, 5'h03, 8'h00, 8'hA5, 0);

    // back-pressure on a read
    do_access(1'b0, 5'h03, 8'h00, 8'hA5, 5);

    // read-after-write on consecutive responses, several patterns
    do_access(1'b1, 5'h07, 8'h3C, 8'h00, 0);
    do_access(1'b0, 5'h07, 8'h00, 8'h3C, 0);
    do_access(1'b1, 5'h1F, 8'hFF, 8'h00, 0);
    do_access(1'b0, 5'h1F, 8'h00, 8'hFF, 1);

    // loader: 33 bytes wrap over a 32-byte memory
    load_en = 1'b1;
    for (int i = 0; i < 33; i++) begin
      load_byte = 8'(i);
      #1;
      if (i == 0) check_val("load_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    load_en = 1'b0;
    do_access(1'b0, 5'h00, 8'h00, 8'h20, 0);
    do_access(1'b0, 5'h01, 8'h00, 8'h01, 0);
    do_access(1'b0, 5'h1E, 8'h00, 8'h1E, 0);

    // loader wins over a simultaneous request
    load_en   = 1'b1;
    load_byte = 8'h5C;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 5'h00;
    #1;
    check_val("prio_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check_val("prio_not_accepted", 32'(busy), 32'd0);
    load_en = 1'b0;
    #1;
    check_val("prio_ready_after", 32'(req_ready), 32'd1);
    do_access(1'b0, 5'h00, 8'h00, 8'h5C, 0);

    // reset during WAIT aborts the write
    do_access(1'b1, 5'h02, 8'h11, 8'h00, 0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 5'h02;
    req_wdata = 8'h7E;
    @(negedge clk);
    req_valid = 1'b0;
    check_val("abort_in_wait", 32'(dbg_state), 32'(WAIT));
    check_val("abort_busy_pre", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("abort_state", 32'(dbg_state), 32'(IDLE));
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_access(1'b0, 5'h02, 8'h00, 8'h11, 0);

`ifdef EXT_MEM_PARITY_EN
    do_access(1'b1, 5'h04, 8'h5A, 8'h00, 0);
    do_access(1'b1, 5'h05, 8'h33, 8'h00, 0);
    dut.u_array.r_par[4] = ~dut.u_array.r_par[4];
    exp_perr = 1'b1;
    do_access(1'b0, 5'h04, 8'h00, 8'h5A, 0);
    exp_perr = 1'b0;
    do_access(1'b0, 5'h05, 8'h00, 8'h33, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ext_mem_responder.md
EXT_MEM_RESPONDER -- requirements
Module: ext_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, giving address width and a memory depth of 2**ADDR_W bytes.
REQ-002 SHALL have parameter WAIT_CYC, default 1, giving wait cycles inserted per access (range 0-15).
REQ-003 SHALL have port clk  in  1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1, reset: asynchronous, active-high.
REQ-005 SHALL have port req_valid  in  1, CPU request present.
REQ-006 SHALL have port req_ready  out  1, responder accepts request this cycle.
REQ-007 SHALL have port req_we  in  1, 1 = write, 0 = read.
REQ-008 SHALL have ports req_addr  in  ADDR_W and req_wdata  in  8, request address and write data.
REQ-009 SHALL have ports rsp_valid  out  1 and rsp_ready  in  1, response handshake.
REQ-010 SHALL have port rsp_rdata  out  8, read data; 0 for write responses.
REQ-011 SHALL have ports load_en  in  1 and load_byte  in  8, byte-stream program loader.
REQ-012 SHALL have port busy  out  1, high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 In IDLE, req_ready SHALL be 1 unless load_en=1; a transfer occurs when req_valid and req_ready are both 1.
REQ-015 On transfer: latch we/addr/wdata; go to WAIT if WAIT_CYC>0, else RESP.
REQ-016 WAIT SHALL count exactly WAIT_CYC cycles and then go to RESP; the first request-to-rsp_valid latency is therefore WAIT_CYC+1 cycles.
REQ-017 Writes SHALL commit to memory on the WAIT->RESP (or IDLE->RESP) edge; reads SHALL sample memory on the same edge into rsp_rdata.
REQ-018 In RESP, rsp_valid=1 with stable rsp_rdata until rsp_ready=1; then go to IDLE.
REQ-019 req_ready SHALL be 0 in WAIT and RESP; there is no request pipelining.
REQ-020 Loader: while load_en=1 and FSM in IDLE, each cycle SHALL write load_byte at load pointer and increment it, wrapping from 2**ADDR_W-1 to 0.
REQ-021 load_en=1 outside IDLE SHALL be ignored until IDLE is reached; a load cycle SHALL take priority over a simultaneous CPU request.
REQ-022 The load pointer SHALL reset to 0 when load_en falls.
REQ-023 A read of an address written in the previous response SHALL return the new data.

Reset
REQ-024 rst SHALL asynchronously force IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, busy=0, wait counter=0, load pointer=0.
REQ-025 Memory contents SHALL NOT be cleared by rst; rst mid-access SHALL abort it with no write committed.

Configuration
REQ-026 Macro EXT_MEM_PARITY_EN SHALL, when defined, store an even-parity bit per byte and add output port rsp_perr (1 bit), asserted with rsp_valid when read parity mismatches; reset 0.
REQ-027 Without EXT_MEM_PARITY_EN, no parity storage and no rsp_perr port SHALL exist.

Structure
REQ-028 A shared package ext_mem_pkg SHALL hold the FSM state typedef (IDLE/WAIT/RESP) and the WAIT_CYC width constant.
REQ-029 Storage SHALL be the sub-module ext_mem_array (synchronous write, combinational read, optional parity column).

Verification
REQ-030 Reset then write addr 0x03 data 0xA5, read addr 0x03 with WAIT_CYC=1 -> rsp_valid 2 cycles after accept, rsp_rdata=0xA5.
REQ-031 Hold rsp_ready=0 for 5 cycles on a read -> rsp_valid and rsp_rdata stable, req_ready=0 throughout.
REQ-032 Load 33 bytes 0x00..0x20 with ADDR_W=5 -> addr 0 reads 0x20 (wrap), addr 1 reads 0x01.
REQ-033 Assert load_en and req_valid in the same IDLE cycle -> load byte written, req_ready=0, request accepted after load_en falls.
REQ-034 Assert rst during WAIT of write 0x7E to addr 2 (prior 0x11) -> IDLE immediately, later read of addr 2 returns 0x11.
REQ-035 With EXT_MEM_PARITY_EN, force a flipped parity bit at addr 4 -> read returns rsp_perr=1; a clean address returns rsp_perr=0.
